uart_tx: RTL and testbench

- 8N1 UART transmitter; the transmit-side counterpart of the UART receiver in the same serial link.
- Accepts a byte from a local producer with a start/busy handshake.
- Serialises the byte LSB first on a single idle-high line, with fixed baud timing derived from the 100 MHz system clock.
- Sits between the host-side logic and the TX pin.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_counter.sv | 37 +++
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, data width and FSM state encodings.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 10416;  // 100 MHz / 9600 baud
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_tick_o on the last count.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_tick_o
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = enable_i && !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      // wrap on the tick so the next bit period starts at zero
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, registered tx output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_start,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx,
  output logic                      tx_busy,
  output logic                      tx_done
);

  // state  | meaning
  // IDLE   | line high, waiting for tx_start
  // START  | start bit (low) for one bit period
  // DATA   | eight data bits, LSB first
  // PARITY | even parity bit (only with UART_TX_PARITY_EN)
  // STOP   | stop bit (high); tx_done pulses on exit

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      bit_tick;

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (state_q == IDLE),
    .enable_i   (state_q != IDLE),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        if (tx_start) begin
          shift_d = tx_data;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d      = ^shift_q;
            state_d   = PARITY;
`else
            tx_d      = 1'b1;
            state_d   = STOP;
`endif
          end else begin
            // shift_q is never shifted, so parity can still be taken from it
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[bit_cnt_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit; frames are decoded bit by bit from the line.
module tb_uart_tx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, tx_done;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at the negedge of the first start-bit cycle, ends at the negedge where tx_done is expected.
  task automatic check_frame(input string name, input logic [7:0] d, input int nbits, input logic par);
    int   bad_busy = 0;
    int   done_cnt = 0;
    logic first = 1'b0;
    logic exp;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)                    exp = 1'b0;
      else if (b <= 8)               exp = d[b-1];
      else if (b == 9 && nbits == 11) exp = par;
      else                           exp = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (c == 0) first = tx;
        if (!tx_busy) bad_busy++;
        if (tx_done) done_cnt++;
        if (c == CPB - 1) check($sformatf("%s_bit%0d", name, b), {first, tx}, {exp, exp});
        @(negedge clk);
      end
    end
    check({name, "_busy_in_frame"}, bad_busy, 0);
    check({name, "_done_early"}, done_cnt, 0);
    check({name, "_done_pulse"}, tx_done, 1);
    check({name, "_tx_idle"}, tx, 1);
    check({name, "_busy_end"}, tx_busy, 0);
  endtask

  task automatic start_byte(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int quiet_bad;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single byte 0xA5
    start_byte(8'hA5);
    check_frame("a5", 8'hA5, 10, 1'b0);
    @(negedge clk);
    check("a5_done_one_cycle", tx_done, 0);
    repeat (3) @(negedge clk);

    // back-to-back 0x00 then 0xFF, second start in the tx_done cycle
    start_byte(8'h00);
    check_frame("b00", 8'h00, 10, 1'b0);
    start_byte(8'hFF);
    check_frame("bff", 8'hFF, 10, 1'b0);
    @(negedge clk);
    repeat (3) @(negedge clk);

    // tx_start held high: repeated frames with one idle cycle, no mid-frame restart
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    @(negedge clk);
    check_frame("h1", 8'h3C, 10, 1'b0);
    @(negedge clk);
    check_frame("h2", 8'h3C, 10, 1'b0);
    tx_start = 1'b0;
    @(negedge clk);
    check("held_release_tx", tx, 1);
    check("held_release_busy", tx_busy, 0);
    repeat (3) @(negedge clk);

    // tx_data changed during DATA does not affect the frame
    start_byte(8'h0F);
    fork
      check_frame("d0f", 8'h0F, 10, 1'b0);
      begin
        repeat (40) @(negedge clk);
        tx_data = 8'h55;
      end
    join
    repeat (3) @(negedge clk);

    // reset during data bit 4 of 0x81
    start_byte(8'h81);
    repeat (85) @(negedge clk);
    check("r81_before_rst_tx", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    check("r81_rst_tx", tx, 1);
    check("r81_rst_busy", tx_busy, 0);
    check("r81_rst_done", tx_done, 0);
    rst = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (tx_done || !tx || tx_busy) quiet_bad++;
      @(negedge clk);
    end
    check("r81_quiet_after_rst", quiet_bad, 0);
    start_byte(8'h81);
    check_frame("r81_retry", 8'h81, 10, 1'b0);
    repeat (3) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    // even parity of 0x07 is 1; frame is 11 bit periods
    start_byte(8'h07);
    check_frame("p07", 8'h07, 11, 1'b1);
    repeat (3) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
